// File: rtl/sdspi_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdspi_arb_pkg : shared types and defaults for the SD-SPI host arbiter (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package sdspi_arb_pkg;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_BUSY_TIMEOUT = 1 << 24;

  typedef enum logic [2:0] {
    INIT_RST  = 3'd0,
    INIT_WAIT = 3'd1,
    IDLE      = 3'd2,
    OWNED     = 3'd3,
    RECOVER   = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic        r_block;
    logic        r_multi_block;
    logic        r_byte;
    logic        w_block;
    logic        w_byte;
    logic [31:0] addr;
    logic [7:0]  data;
  } sd_cmd_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdspi_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker : combinational round-robin priority encoder (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW:0] cand;

  // Scan from ptr upward and wrap; the first requester found wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!valid && req[cand[IW-1:0]]) begin
        valid                 = 1'b1;
        idx                   = cand[IW-1:0];
        onehot[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdspi_arbiter.sv
// ---------------------------------------------------------------------------
// sdspi_arbiter : shares one SD-SPI host among N_REQ requesters (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sdspi_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int W_TO         = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  output logic [N_REQ-1:0]     grant,
  input  logic [N_REQ-1:0]     req_r_block,
  input  logic [N_REQ-1:0]     req_r_multi_block,
  input  logic [N_REQ-1:0]     req_r_byte,
  input  logic [N_REQ-1:0]     req_w_block,
  input  logic [N_REQ-1:0]     req_w_byte,
  input  logic [32*N_REQ-1:0]  req_block_addr,
  input  logic [8*N_REQ-1:0]   req_data_in,
  output logic [N_REQ-1:0]     req_busy,
  output logic [7:0]           data_out,
  output logic                 host_err,
  output logic                 ready,
  output logic                 timeout,
  output logic                 spi_rst,
  output logic                 spi_r_block,
  output logic                 spi_r_multi_block,
  output logic                 spi_r_byte,
  output logic                 spi_w_block,
  output logic                 spi_w_byte,
  output logic [31:0]          spi_block_addr,
  output logic [7:0]           spi_data_in,
  input  logic                 spi_busy,
  input  logic                 spi_err,
  input  logic [7:0]           spi_data_out
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RC_W = $clog2(RST_CYCLES + 1);

  arb_state_t       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [RC_W-1:0]  rst_cnt;
  logic [W_TO-1:0]  wd_cnt;
  logic [W_TO-1:0]  wd_next;
  logic             wd_fire;

  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  sd_cmd_t          cmd [N_REQ];
  sd_cmd_t          host_cmd;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Strobes pass only while the owner still holds its request.
  for (genvar i = 0; i < N_REQ; i++) begin : g_cmd
    logic live;
    assign live   = grant[i] & req[i];
    assign cmd[i] = '{
      r_block:       live & req_r_block[i],
      r_multi_block: live & req_r_multi_block[i],
      r_byte:        live & req_r_byte[i],
      w_block:       live & req_w_block[i],
      w_byte:        live & req_w_byte[i],
      addr:          req_block_addr[32*i +: 32],
      data:          req_data_in[8*i +: 8]
    };
    assign req_busy[i] = grant[i] ? spi_busy : 1'b1;
  end

  always_comb begin
    host_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) host_cmd = cmd[i];
    end
  end

  assign spi_r_block       = host_cmd.r_block;
  assign spi_r_multi_block = host_cmd.r_multi_block;
  assign spi_r_byte        = host_cmd.r_byte;
  assign spi_w_block       = host_cmd.w_block;
  assign spi_w_byte        = host_cmd.w_byte;
  assign spi_block_addr    = host_cmd.addr;
  assign spi_data_in       = host_cmd.data;
  assign data_out          = spi_data_out;
  assign host_err          = spi_err;

  assign wd_fire = (wd_cnt >= W_TO'(BUSY_TIMEOUT - 1));
  assign wd_next = (&wd_cnt) ? wd_cnt : wd_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT_RST;
      grant   <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      rst_cnt <= '0;
      wd_cnt  <= '0;
      spi_rst <= 1'b1;
      ready   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        INIT_RST: begin
          spi_rst <= 1'b1;
          ready   <= 1'b0;
          grant   <= '0;
          wd_cnt  <= '0;
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            state   <= INIT_WAIT;
            spi_rst <= 1'b0;
            rst_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        INIT_WAIT: begin
          if (!spi_busy) begin
            state  <= IDLE;
            ready  <= 1'b1;
            wd_cnt <= '0;
          end else if (wd_fire) begin
            state   <= RECOVER;
            ready   <= 1'b0;
            timeout <= 1'b1;
            wd_cnt  <= '0;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        IDLE: begin
          wd_cnt <= '0;
          if (pick_valid) begin
            grant <= pick_onehot;
            owner <= pick_idx;
            state <= OWNED;
          end
        end
        OWNED: begin
          // Ownership ends only once the host is idle, so an early req drop
          // still lets the in-flight transfer finish.
          if (!spi_busy) begin
            wd_cnt <= '0;
            if (!req[owner]) begin
              grant  <= '0;
              rr_ptr <= IW'(wrap_inc(int'(owner), N_REQ));
              state  <= IDLE;
            end
          end else if (wd_fire) begin
            grant   <= '0;
            ready   <= 1'b0;
            timeout <= 1'b1;
            wd_cnt  <= '0;
            state   <= RECOVER;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        RECOVER: begin
          grant   <= '0;
          ready   <= 1'b0;
          spi_rst <= 1'b1;
          rst_cnt <= '0;
          wd_cnt  <= '0;
          state   <= INIT_RST;
        end
        default: begin
          state <= INIT_RST;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
